// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory, single-ALU datapath, with memory-wait timeout into a sticky ERROR.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OP,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCondEQ,
   output logic       PCWriteCondNE,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       error,
   output logic [3:0] state
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_I_EXEC   = 4'd8,
      S_I_WB     = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   state_t        cur;
   state_t        nxt;
   logic [CW-1:0] wait_cnt;
   logic          mem_state;
   logic          timeout;

   assign state     = cur;
   assign mem_state = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
   // ready wins over timeout: timeout only fires on a not-ready cycle
   assign timeout   = mem_state && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur      <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         cur <= nxt;
         if (nxt != cur)
            wait_cnt <= '0;
         else if (mem_state && !mem_ready)
            wait_cnt <= wait_cnt + CW'(1);
      end
   end

   always_comb begin
      nxt           = cur;
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      ALUOp         = 3'b000;
      error         = 1'b0;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            ALUOp   = 3'b010;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)    nxt = S_DECODE;
            else if (timeout) nxt = S_ERROR;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            ALUOp   = 3'b010;
            case (OP)
               OP_R:                            nxt = S_R_EXEC;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt = S_I_EXEC;
               OP_LW, OP_SW:                    nxt = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                  nxt = S_BRANCH;
               OP_J:                            nxt = S_JUMP;
               default:                         nxt = S_ERROR;
            endcase
         end
         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b111;
            nxt     = S_R_WB;
         end
         S_R_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            nxt      = S_FETCH;
         end
         S_I_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (OP)
               OP_ADDI: ALUOp = 3'b110;
               OP_ANDI: ALUOp = 3'b011;
               OP_ORI:  ALUOp = 3'b101;
               OP_LUI:  ALUOp = 3'b001;
               default: ALUOp = 3'b000;
            endcase
            nxt = S_I_WB;
         end
         S_I_WB: begin
            RegWrite = 1'b1;
            nxt      = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 3'b010;
            if (OP == OP_LW)      nxt = S_MEM_RD;
            else if (OP == OP_SW) nxt = S_MEM_WR;
            else                  nxt = S_ERROR;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready)    nxt = S_MEM_WB;
            else if (timeout) nxt = S_ERROR;
         end
         S_MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            nxt      = S_FETCH;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready)    nxt = S_FETCH;
            else if (timeout) nxt = S_ERROR;
         end
         S_BRANCH: begin
            ALUSrcA       = 1'b1;
            ALUOp         = 3'b100;
            PCSource      = 2'b01;
            PCWriteCondEQ = (OP == OP_BEQ);
            PCWriteCondNE = (OP == OP_BNE);
            nxt           = S_FETCH;
         end
         S_JUMP: begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
            nxt      = S_FETCH;
         end
         S_ERROR: error = 1'b1;
         default: nxt = S_ERROR;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level generator drives
// opcodes and memory waits and queues the per-cycle expected control word.
module tb_multicycle_control;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] OP = 6'h00;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, error;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic [3:0] state;

   multicycle_control #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .error(error), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, ceq, cne, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, pcs;
      logic [2:0] aop;
      logic       err;
      logic [3:0] st;
   } vec_t;

   vec_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail = 0;

   // Expected word for one cycle: everything zero except the named state.
   function automatic vec_t z(input int s);
      vec_t v;
      v    = '0;
      v.st = s[3:0];
      return v;
   endfunction

   function automatic vec_t fetch_v(input logic r);
      vec_t v;
      v     = z(0);
      v.mrd = 1'b1;
      v.asb = 2'b01;
      v.aop = 3'b010;
      v.irw = r;
      v.pcw = r;
      return v;
   endfunction

   function automatic vec_t mem_v(input int s, input logic r);
      vec_t v;
      if (s == 0) return fetch_v(r);
      v      = z(s);
      v.iord = 1'b1;
      if (s == 3) v.mrd = 1'b1;
      else        v.mwr = 1'b1;
      return v;
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
   endfunction

   // One clock cycle: drive inputs mid-cycle, queue what the outputs must be.
   task automatic cyc(input logic [5:0] op, input logic rdy, input logic rst,
                      input vec_t e, input string nm);
      @(posedge clk);
      #2;
      reset     = rst;
      OP        = op;
      mem_ready = rdy;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic rcyc(input logic [5:0] op, input vec_t e, input string nm);
      cyc(op, 1'($urandom_range(0, 1)), 1'b1, e, nm);
   endtask

   // w not-ready cycles then a ready one; T not-ready cycles in a row is a timeout.
   task automatic mem_wait(input int w, input int s, input logic [5:0] op,
                           input string nm, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < T && i < w; i++)
         cyc(op, 1'b0, 1'b1, mem_v(s, 1'b0), nm);
      if (w < T) begin
         cyc(op, 1'b1, 1'b1, mem_v(s, 1'b1), nm);
         ok = 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      logic r;
      for (int i = 0; i < n; i++) begin
         r = 1'($urandom_range(0, 1));
         cyc(6'($urandom), r, 1'b0, fetch_v(r), "reset");
      end
   endtask

   task automatic err_then_reset();
      vec_t e;
      e     = z(12);
      e.err = 1'b1;
      for (int i = 0; i < int'($urandom_range(2, 5)); i++)
         rcyc(6'($urandom), e, "error_hold");
      do_reset(2);
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      vec_t e;
      bit   ok;
      mem_wait(wf, 0, op, "fetch", ok);
      if (!ok) begin
         err_then_reset();
         return;
      end
      e = z(1); e.asb = 2'b11; e.aop = 3'b010;
      rcyc(op, e, "decode");
      ok = 1'b1;
      case (op)
         6'h00: begin
            e = z(6); e.asa = 1'b1; e.aop = 3'b111;
            rcyc(op, e, "r_exec");
            e = z(7); e.rdst = 1'b1; e.rw = 1'b1;
            rcyc(op, e, "r_wb");
         end
         6'h08, 6'h0c, 6'h0d, 6'h0f: begin
            e = z(8); e.asa = 1'b1; e.asb = 2'b10;
            e.aop = (op == 6'h08) ? 3'b110 : (op == 6'h0c) ? 3'b011 :
                    (op == 6'h0d) ? 3'b101 : 3'b001;
            rcyc(op, e, "i_exec");
            e = z(9); e.rw = 1'b1;
            rcyc(op, e, "i_wb");
         end
         6'h23, 6'h2b: begin
            e = z(2); e.asa = 1'b1; e.asb = 2'b10; e.aop = 3'b010;
            rcyc(op, e, "mem_addr");
            if (op == 6'h23) begin
               mem_wait(wm, 3, op, "mem_rd", ok);
               if (ok) begin
                  e = z(4); e.m2r = 1'b1; e.rw = 1'b1;
                  rcyc(op, e, "mem_wb");
               end
            end else begin
               mem_wait(wm, 5, op, "mem_wr", ok);
            end
         end
         6'h04, 6'h05: begin
            e = z(10); e.asa = 1'b1; e.aop = 3'b100; e.pcs = 2'b01;
            e.ceq = (op == 6'h04); e.cne = (op == 6'h05);
            rcyc(op, e, "branch");
         end
         6'h02: begin
            e = z(11); e.pcs = 2'b10; e.pcw = 1'b1;
            rcyc(op, e, "jump");
         end
         default: ok = 1'b0;
      endcase
      if (!ok) err_then_reset();
   endtask

   // SW interrupted by reset while waiting on memory.
   task automatic sw_abort(input int k);
      vec_t e;
      bit   ok;
      mem_wait(0, 0, 6'h2b, "fetch", ok);
      e = z(1); e.asb = 2'b11; e.aop = 3'b010;
      rcyc(6'h2b, e, "decode");
      e = z(2); e.asa = 1'b1; e.asb = 2'b10; e.aop = 3'b010;
      rcyc(6'h2b, e, "mem_addr");
      for (int i = 0; i < k; i++)
         cyc(6'h2b, 1'b0, 1'b1, mem_v(5, 1'b0), "mem_wr");
      cyc(6'h2b, 1'b0, 1'b0, fetch_v(1'b0), "async_reset");
      do_reset(1);
   endtask

   function automatic int pick_wait();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70) return int'($urandom_range(0, 2));
      if (r < 85) return int'($urandom_range(3, 8));
      if (r < 95) return T - 1;
      return T;
   endfunction

   // Monitor: one expected word per cycle, compared on the falling edge.
   initial begin
      vec_t  act;
      vec_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
                   IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                   ALUOp, error, state};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s @%0t: got state=%0d word=%h, expected state=%0d word=%h",
                        nm, $time, act.st, act, e.st, e);
            end
         end
      end
   end

   logic [5:0] legal_ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                  6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

   initial begin
      logic [5:0] op;
      do_reset(3);
      run_instr(6'h00, 0, 0);
      run_instr(6'h23, 0, 3);
      run_instr(6'h04, 0, 0);
      run_instr(6'h05, 1, 0);
      run_instr(6'h2b, 0, T);
      run_instr(6'h3f, 0, 0);
      run_instr(6'h23, 0, T - 1);
      run_instr(6'h2b, T - 1, T - 1);
      sw_abort(5);
      run_instr(6'h00, T - 1, 0);
      run_instr(6'h02, T, 0);
      for (int n = 0; n < 200; n++) begin
         op = legal_ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 99) < 6) begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
         end
         if ($urandom_range(0, 99) < 3) sw_abort(int'($urandom_range(1, T - 1)));
         else run_instr(op, pick_wait(), pick_wait());
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
